// File: rtl/fpu_pipe_drain_pkg.sv
// -----------------------------------------------------------------------------
// float_struct: shared single-precision float types for the FPU datapath.
// Holds the packed float layout, the result classification enum and a
// classifier helper used by the output drain when classification is built.
// -----------------------------------------------------------------------------
package float_struct;

   localparam int FP_WIDTH   = 32;
   localparam int FP_CLASS_W = 3;

   localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
   localparam logic [7:0]  FP_EXP_MIN  = 8'h00;
   localparam logic [22:0] FP_MAN_ZERO = 23'h000000;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exponent;
      logic [22:0] mantissa;
   } float_point_num;

   typedef enum logic [2:0] {
      FP_ZERO = 3'd0,
      FP_SUB  = 3'd1,
      FP_NORM = 3'd2,
      FP_INF  = 3'd3,
      FP_NAN  = 3'd4
   } fp_class_t;

   // Classify a float by its exponent/mantissa; the sign is irrelevant.
   function automatic fp_class_t fp_classify(input float_point_num v);
      fp_class_t c;
      if (v.exponent == FP_EXP_MIN) begin
         c = (v.mantissa == FP_MAN_ZERO) ? FP_ZERO : FP_SUB;
      end else if (v.exponent == FP_EXP_MAX) begin
         c = (v.mantissa == FP_MAN_ZERO) ? FP_INF : FP_NAN;
      end else begin
         c = FP_NORM;
      end
      return c;
   endfunction

endpackage

// File: rtl/fpu_pipe_drain_if.sv
// -----------------------------------------------------------------------------
// fpu_pipe_drain_if: pipeline-tail input, downstream valid/ready output and
// status signals of the FPU output drain. The slave modport is the drain
// itself; the master modport is the surrounding pipeline/consumer side.
// -----------------------------------------------------------------------------
interface fpu_pipe_drain_if #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) ();
   import float_struct::*;

   logic                     pipe_valid_i;
   float_point_num           pipe_data_i;
   logic                     pipe_en_o;
   logic                     out_valid_o;
   logic                     out_ready_i;
   float_point_num           out_data_o;
   fp_class_t                out_class_o;
   logic [$clog2(DEPTH):0]   level_o;
   logic [CNT_W-1:0]         retired_o;

   modport slave (
      input  pipe_valid_i,
      input  pipe_data_i,
      input  out_ready_i,
      output pipe_en_o,
      output out_valid_o,
      output out_data_o,
      output out_class_o,
      output level_o,
      output retired_o
   );

   modport master (
      output pipe_valid_i,
      output pipe_data_i,
      output out_ready_i,
      input  pipe_en_o,
      input  out_valid_o,
      input  out_data_o,
      input  out_class_o,
      input  level_o,
      input  retired_o
   );

endinterface

// File: rtl/fpu_pipe_drain_fifo.sv
// -----------------------------------------------------------------------------
// fpu_drain_fifo: generic synchronous FIFO with a registered head.
// The head register always holds the entry that will be popped next, so the
// consumer sees a clean flop output. There is no empty bypass: a push into an
// empty FIFO shows up on the head one cycle later. Push and pop in the same
// cycle are legal at any occupancy, including full and empty (when empty the
// pop is ignored). DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fpu_drain_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] level,
   output logic                   not_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] rd_ptr_nxt_s;
   logic [LVL_W-1:0] level_r;
   logic [LVL_W-1:0] level_nxt_s;
   logic [LVL_W-1:0] remain_s;
   logic [WIDTH-1:0] head_r;
   logic [WIDTH-1:0] head_nxt_s;
   logic             not_empty_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Qualify requests: never pop an empty FIFO, never overwrite a full one
   // unless the head is leaving in the same cycle.
   always_comb begin
      pop_ok_s  = pop & (level_r != LVL_ZERO);
      push_ok_s = push & ((level_r != LVL_FULL) | pop_ok_s);
   end

   // Next occupancy and read pointer; remain_s is what is left after the pop.
   always_comb begin
      level_nxt_s = level_r;
      case ({push_ok_s, pop_ok_s})
         2'b10:   level_nxt_s = level_r + LVL_W'(1'b1);
         2'b01:   level_nxt_s = level_r - LVL_W'(1'b1);
         default: level_nxt_s = level_r;
      endcase
      if (pop_ok_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1'b1);
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      remain_s = level_r - LVL_W'(pop_ok_s);
   end

   // Next head: the incoming word if nothing older survives, else storage.
   always_comb begin
      head_nxt_s = head_r;
      if (level_nxt_s == LVL_ZERO) begin
         head_nxt_s = head_r;
      end else if (push_ok_s && (remain_s == LVL_ZERO)) begin
         head_nxt_s = push_data;
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end
   end

   // Pointer, occupancy and head registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         level_r     <= LVL_ZERO;
         head_r      <= {WIDTH{1'b0}};
         not_empty_r <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         rd_ptr_r    <= rd_ptr_nxt_s;
         level_r     <= level_nxt_s;
         head_r      <= head_nxt_s;
         not_empty_r <= (level_nxt_s != LVL_ZERO);
      end
   end

   // Entry storage; contents are only meaningful between wr and rd pointers.
   always_ff @(posedge clk) begin
      if (push_ok_s && !rst) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   assign head      = head_r;
   assign level     = level_r;
   assign not_empty = not_empty_r;

endmodule

// File: rtl/fpu_pipe_drain.sv
// -----------------------------------------------------------------------------
// fpu_pipe_drain: output drain for the enable-gated FPU pipeline.
// Captures tail-stage results into a small FIFO, presents them downstream on
// valid/ready and generates the pipeline advance enable so a stalled consumer
// holds the whole pipeline instead of dropping results. pipe_en_o is the only
// combinational path (from out_ready_i); all other outputs are flops.
// Build option: define FPU_DRAIN_CLASSIFY_EN to classify each result at push
// time and carry the class with it; otherwise out_class_o is tied to FP_ZERO.
// -----------------------------------------------------------------------------
module fpu_pipe_drain
   import float_struct::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   fpu_pipe_drain_if.slave      bus
);

   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

`ifdef FPU_DRAIN_CLASSIFY_EN
   localparam int ENTRY_W = FP_WIDTH + FP_CLASS_W;
`else
   localparam int ENTRY_W = FP_WIDTH;
`endif

   logic               pop_s;
   logic               push_s;
   logic               pipe_en_s;
   logic               valid_s;
   logic [LVL_W-1:0]   level_s;
   logic [ENTRY_W-1:0] push_entry_s;
   logic [ENTRY_W-1:0] head_entry_s;
   logic [CNT_W-1:0]   retired_r;

   // Handshake: pipeline advances when a slot is free or the head leaves now.
   always_comb begin
      pop_s     = valid_s & bus.out_ready_i;
      pipe_en_s = ~rst & ((level_s < DEPTH_L) | pop_s);
      push_s    = pipe_en_s & bus.pipe_valid_i;
   end

`ifdef FPU_DRAIN_CLASSIFY_EN
   assign push_entry_s    = {fp_classify(bus.pipe_data_i), bus.pipe_data_i};
   assign bus.out_data_o  = float_point_num'(head_entry_s[FP_WIDTH-1:0]);
   assign bus.out_class_o = fp_class_t'(head_entry_s[ENTRY_W-1:FP_WIDTH]);
`else
   assign push_entry_s    = bus.pipe_data_i;
   assign bus.out_data_o  = float_point_num'(head_entry_s);
   assign bus.out_class_o = FP_ZERO;
`endif

   fpu_drain_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data (push_entry_s),
      .pop       (pop_s),
      .head      (head_entry_s),
      .level     (level_s),
      .not_empty (valid_s)
   );

   // Count results handed to the consumer; wraps silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_r <= {CNT_W{1'b0}};
      end else if (pop_s) begin
         retired_r <= retired_r + CNT_W'(1'b1);
      end else begin
         retired_r <= retired_r;
      end
   end

   assign bus.pipe_en_o   = pipe_en_s;
   assign bus.out_valid_o = valid_s;
   assign bus.level_o     = level_s;
   assign bus.retired_o   = retired_r;

endmodule

// File: tb/tb_fpu_pipe_drain.sv
// -----------------------------------------------------------------------------
// tb_fpu_pipe_drain: self-checking bench for fpu_pipe_drain.
// A queue-based reference model predicts occupancy, head, class, enable and
// the retired count every cycle; the bench itself plays the upstream pipeline
// (holding the tail value while the enable is low). Expected classes follow
// FPU_DRAIN_CLASSIFY_EN. A second instance with CNT_W=4 checks counter wrap.
// -----------------------------------------------------------------------------
module tb_fpu_pipe_drain;
   import float_struct::*;

   localparam int DEPTH  = 4;
   localparam int CNT_W  = 16;
   localparam int CNT_W2 = 4;
`ifdef FPU_DRAIN_CLASSIFY_EN
   localparam bit CLASSIFY = 1'b1;
`else
   localparam bit CLASSIFY = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   fpu_pipe_drain_if #(.DEPTH(DEPTH), .CNT_W(CNT_W))  bus1 ();
   fpu_pipe_drain_if #(.DEPTH(DEPTH), .CNT_W(CNT_W2)) bus2 ();

   fpu_pipe_drain #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   fpu_pipe_drain #(.DEPTH(DEPTH), .CNT_W(CNT_W2)) dut_small (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   float_point_num mq[$];
   int unsigned    m_ret = 0;
   bit             m_pop, m_en, m_push;

   typedef struct {
      logic [31:0] data;
      fp_class_t   cls;
   } vec_t;
   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic fp_class_t ref_class(input logic [31:0] bits);
      int e;
      int m;
      e = int'(bits >> 23) & 255;
      m = int'(bits & 32'h007FFFFF);
      if (!CLASSIFY) return FP_ZERO;
      if (e == 0)   return (m == 0) ? FP_ZERO : FP_SUB;
      if (e == 255) return (m == 0) ? FP_INF : FP_NAN;
      return FP_NORM;
   endfunction

   function automatic float_point_num rand_fp();
      float_point_num v;
      v = float_point_num'($urandom);
      case ($urandom_range(0, 4))
         32'd0:   v.exponent = 8'h00;
         32'd1:   v.exponent = 8'hFF;
         default: v.exponent = v.exponent;
      endcase
      if ($urandom_range(0, 3) == 0) v.mantissa = 23'd0;
      return v;
   endfunction

   // At the negative edge: predict this cycle and compare all outputs.
   task automatic neg_check();
      @(negedge clk);
      m_pop  = (mq.size() != 0) && (bus1.out_ready_i == 1'b1);
      m_en   = (mq.size() < DEPTH) || m_pop;
      m_push = m_en && (bus1.pipe_valid_i == 1'b1);
      chk("pipe_en", 32'(bus1.pipe_en_o), 32'(m_en));
      chk("level", 32'(bus1.level_o), 32'(mq.size()));
      chk("out_valid", 32'(bus1.out_valid_o), 32'(mq.size() != 0));
      chk("retired", 32'(bus1.retired_o), 32'(m_ret & 32'h0000FFFF));
      if (mq.size() != 0) begin
         chk("head_data", 32'(bus1.out_data_o), 32'(mq[0]));
         chk("head_class", 32'(bus1.out_class_o), 32'(ref_class(mq[0])));
      end
   endtask

   // Active edge: apply the predicted push/pop to the model.
   task automatic edge_step();
      float_point_num cap;
      cap = bus1.pipe_data_i;
      @(posedge clk);
      if (m_pop) begin
         void'(mq.pop_front());
         m_ret++;
      end
      if (m_push) mq.push_back(cap);
      #1;
   endtask

   task automatic step();
      neg_check();
      edge_step();
   endtask

   task automatic drain();
      bus1.pipe_valid_i = 1'b0;
      bus1.out_ready_i  = 1'b1;
      for (int c = 0; c < 10 && mq.size() != 0; c++) step();
      chk("drain_empty", 32'(mq.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      float_point_num vals[6];
      float_point_num got[$];
      float_point_num cur;
      bit             cur_v;
      int             k;
      int             pops;

      vecs[0] = '{32'h3F800000, FP_NORM};
      vecs[1] = '{32'h7F800000, FP_INF};
      vecs[2] = '{32'h7FC00000, FP_NAN};
      vecs[3] = '{32'h00000001, FP_SUB};
      vecs[4] = '{32'h00000000, FP_ZERO};
      vecs[5] = '{32'h80000000, FP_ZERO};
      vecs[6] = '{32'hFF800000, FP_INF};
      vecs[7] = '{32'h807FFFFF, FP_SUB};
      vecs[8] = '{32'hC0490FDB, FP_NORM};

      bus1.pipe_valid_i = 1'b0;
      bus1.pipe_data_i  = float_point_num'(32'h0);
      bus1.out_ready_i  = 1'b0;
      bus2.pipe_valid_i = 1'b0;
      bus2.pipe_data_i  = float_point_num'(32'h0);
      bus2.out_ready_i  = 1'b0;

      // ---------------- reset ----------------
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pipe_en", 32'(bus1.pipe_en_o), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      mq.delete();
      m_ret = 0;
      neg_check();
      chk("reset_level", 32'(bus1.level_o), 32'd0);
      chk("reset_valid", 32'(bus1.out_valid_o), 32'd0);
      chk("reset_data", 32'(bus1.out_data_o), 32'd0);
      chk("reset_class", 32'(bus1.out_class_o), 32'(FP_ZERO));
      chk("reset_retired", 32'(bus1.retired_o), 32'd0);
      chk("idle_pipe_en", 32'(bus1.pipe_en_o), 32'd1);
      edge_step();
      repeat (3) step();

      // ---------------- table vectors: latency, class, counter ----------------
      for (int i = 0; i < 9; i++) begin
         bus1.out_ready_i  = 1'b1;
         bus1.pipe_valid_i = 1'b1;
         bus1.pipe_data_i  = float_point_num'(vecs[i].data);
         step();
         bus1.pipe_valid_i = 1'b0;
         neg_check();
         chk("vec_valid", 32'(bus1.out_valid_o), 32'd1);
         chk("vec_data", 32'(bus1.out_data_o), vecs[i].data);
         chk("vec_class", 32'(bus1.out_class_o), CLASSIFY ? 32'(vecs[i].cls) : 32'(FP_ZERO));
         edge_step();
         neg_check();
         chk("vec_retired", 32'(bus1.retired_o), 32'(i + 1));
         edge_step();
      end

      // ---------------- 6 pushes into a stalled consumer ----------------
      for (int i = 0; i < 6; i++) vals[i] = rand_fp();
      k = 0;
      bus1.out_ready_i = 1'b0;
      for (int c = 0; c < 8; c++) begin
         bus1.pipe_valid_i = (k < 6);
         bus1.pipe_data_i  = vals[(k < 6) ? k : 5];
         neg_check();
         if (c >= 4) begin
            chk("full_level", 32'(bus1.level_o), 32'd4);
            chk("full_pipe_en", 32'(bus1.pipe_en_o), 32'd0);
            chk("full_stable", 32'(bus1.out_data_o), 32'(vals[0]));
         end
         edge_step();
         if (m_en && bus1.pipe_valid_i) k++;
      end
      bus1.out_ready_i = 1'b1;
      got.delete();
      for (int c = 0; c < 30 && !(k == 6 && mq.size() == 0); c++) begin
         bus1.pipe_valid_i = (k < 6);
         bus1.pipe_data_i  = vals[(k < 6) ? k : 5];
         neg_check();
         if (bus1.out_valid_o && bus1.out_ready_i) got.push_back(bus1.out_data_o);
         edge_step();
         if (m_en && bus1.pipe_valid_i) k++;
      end
      chk("drain6_count", 32'(got.size()), 32'd6);
      for (int i = 0; i < 6 && i < got.size(); i++) chk("drain6_order", 32'(got[i]), 32'(vals[i]));

      // ---------------- full with simultaneous push/pop ----------------
      bus1.out_ready_i  = 1'b0;
      bus1.pipe_valid_i = 1'b1;
      for (int c = 0; c < 10 && mq.size() < DEPTH; c++) begin
         bus1.pipe_data_i = rand_fp();
         step();
      end
      bus1.out_ready_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
         bus1.pipe_data_i = rand_fp();
         neg_check();
         chk("pp_level", 32'(bus1.level_o), 32'd4);
         chk("pp_pipe_en", 32'(bus1.pipe_en_o), 32'd1);
         edge_step();
      end
      drain();

      // ---------------- randomized traffic ----------------
      cur   = rand_fp();
      cur_v = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 400; c++) begin
         bus1.pipe_valid_i = cur_v;
         bus1.pipe_data_i  = cur;
         if (c >= 150 && c < 250) bus1.out_ready_i = ($urandom_range(0, 3) == 0);
         else                     bus1.out_ready_i = ($urandom_range(0, 3) != 0);
         step();
         if (m_en) begin
            cur   = rand_fp();
            cur_v = ($urandom_range(0, 3) != 0);
         end
      end

      // ---------------- reset mid-stream with 3 buffered ----------------
      drain();
      bus1.out_ready_i  = 1'b0;
      bus1.pipe_valid_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         bus1.pipe_data_i = rand_fp();
         step();
      end
      bus1.pipe_valid_i = 1'b0;
      neg_check();
      chk("pre_rst_level", 32'(bus1.level_o), 32'd3);
      edge_step();
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_pipe_en", 32'(bus1.pipe_en_o), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      mq.delete();
      m_ret = 0;
      neg_check();
      chk("post_rst_level", 32'(bus1.level_o), 32'd0);
      chk("post_rst_valid", 32'(bus1.out_valid_o), 32'd0);
      chk("post_rst_retired", 32'(bus1.retired_o), 32'd0);
      edge_step();
      repeat (2) step();

      // ---------------- CNT_W=4 wrap: 17 pops -> 1 ----------------
      bus2.pipe_valid_i = 1'b1;
      bus2.pipe_data_i  = float_point_num'(32'h40000000);
      bus2.out_ready_i  = 1'b1;
      pops = 0;
      for (int c = 0; c < 60 && pops < 17; c++) begin
         @(negedge clk);
         if (bus2.out_valid_o && bus2.out_ready_i) pops++;
         @(posedge clk);
         #1;
      end
      bus2.pipe_valid_i = 1'b0;
      bus2.out_ready_i  = 1'b0;
      @(negedge clk);
      chk("small_pops", 32'(pops), 32'd17);
      chk("small_retired", 32'(bus2.retired_o), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fpu_pipe_drain.md
# fpu_pipe_drain

Output-side drain for the FPU datapath. Consumes `float_point_num` results from the tail of the enable-gated FPU struct pipeline and buffers them in a small FIFO. Presents them downstream over a valid/ready handshake. Generates the pipeline's advance enable, so backpressure from the consumer stalls the whole pipeline and never drops a result.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the retired-result counter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `pipe_valid_i` in 1: tail stage of the FPU pipeline holds a real result.
- `pipe_data_i` in `float_point_num`: tail-stage result.
  - Package `float_struct` fields: `sign` [1], `exponent` [8], `mantissa` [23]; 32 bits total.
- `pipe_en_o` out 1: advance enable for every upstream pipeline register.
- `out_valid_o` out 1: `out_data_o` holds a result.
- `out_ready_i` in 1: consumer accepts this cycle.
- `out_data_o` out `float_point_num`: head of FIFO.
- `out_class_o` out `fp_class_t`: classification of the head entry.
- `level_o` out $clog2(DEPTH)+1: current FIFO occupancy.
- `retired_o` out `CNT_W`: number of results popped since reset.

## Operation
- `pop = out_valid_o & out_ready_i`.
- `pipe_en_o = ~rst & (level_o < DEPTH | pop)`.
  - Combinational from `out_ready_i`; this is the only combinational in-to-out path.
- `push = pipe_en_o & pipe_valid_i`.
  - The tail value is captured on the same edge that shifts it out of the pipeline.
- Occupancy update:
  - push only: `level` +1.
  - pop only: `level` −1.
  - push and pop together: `level` unchanged, valid at any occupancy, including full and empty.
- `out_valid_o = (level != 0)`.
- There is no empty-FIFO bypass. A push into an empty FIFO appears on the following cycle.
- Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- `retired_o` increments on each pop and wraps modulo 2^CNT_W silently.
- Invalid pipeline bubbles (`pipe_valid_i=0`) are never stored and do not alter `level`.
- Classification (`fp_class_t`) is computed at push time and stored alongside the data:
  - `FP_ZERO`: exp=0, man=0.
  - `FP_SUB`: exp=0, man≠0.
  - `FP_INF`: exp=255, man=0.
  - `FP_NAN`: exp=255, man≠0.
  - `FP_NORM`: otherwise.

## Timing
- Reset values:
  - `level_o`=0, `out_valid_o`=0, `out_data_o`=0, `out_class_o`=`FP_ZERO`, `retired_o`=0.
  - `pipe_en_o`=0 while `rst`=1, and 1 on the first cycle after reset.
- Latency: a result pushed at edge N is visible on `out_data_o` after edge N (cycle N+1) when the FIFO was empty. Otherwise it appears once it reaches the head.
- Steady-state throughput: 1 result/cycle with `out_ready_i` held high.
- When full with `out_ready_i`=0: `pipe_en_o`=0, the pipeline holds, and the tail value is re-presented until accepted.
- `out_data_o` and `out_class_o` stay stable while `out_valid_o`=1 and `out_ready_i`=0.
- Reset mid-stream discards all buffered entries and zeroes the counter. Upstream pipeline contents are the upstream reset's responsibility.

## Configuration
- `FPU_DRAIN_CLASSIFY_EN` defined:
  - Classification logic is built.
  - The FIFO stores the 3-bit class with each entry.
  - `out_class_o` is as described in Operation.
- `FPU_DRAIN_CLASSIFY_EN` undefined:
  - No classifier and no class storage.
  - `out_class_o` is tied to `FP_ZERO`.
  - All other behaviour is identical.

## Structure
- Package `float_struct` holds:
  - `float_point_num`.
  - `fp_class_t` (enum logic [2:0]: `FP_ZERO`, `FP_SUB`, `FP_NORM`, `FP_INF`, `FP_NAN`).
  - Constants `FP_EXP_MAX`=8'hFF.
- Sub-module `fpu_drain_fifo`: generic synchronous FIFO (parameters `WIDTH`, `DEPTH`) with push, pop, level, and registered head.
- `fpu_pipe_drain` holds the enable logic, the classifier, and the counter.

## Test plan
- Reset, then idle with `pipe_valid_i`=0 → `pipe_en_o`=1, `out_valid_o`=0, `level_o`=0.
- Push 32'h3F800000 with `out_ready_i`=1 → next cycle `out_data_o`=32'h3F800000, `out_class_o`=`FP_NORM`; following cycle `retired_o`=1.
- DEPTH=4, push 6 consecutive results with `out_ready_i`=0:
  - `pipe_en_o` drops after the 4th push and `level_o`=4.
  - 5th value is held at the tail.
  - Raise ready → all 6 drain in order, no loss.
- Full FIFO plus simultaneous push/pop for 10 cycles → `level_o` stays 4 and order is preserved.
- Push 32'h7F800000, 32'h7FC00000, 32'h00000001, 32'h00000000 → classes `FP_INF`, `FP_NAN`, `FP_SUB`, `FP_ZERO` (`FP_ZERO` for all four when the macro is undefined).
- Assert `rst` with 3 entries buffered → next cycle `level_o`=0, `out_valid_o`=0, `retired_o`=0; with `CNT_W`=4, 17 pops → `retired_o`=1.
